gerenciador_de_ataque_param: RTL and testbench

Parametrised, clocked successor of the naval-battle attack manager. Receives a shot at (coordColuna, coordLinha) on a confirmar press, marks hits in a COLS x ROWS hit matrix against the ship map, and drives the RGB status LEDs. Adds shot budgeting, hit counting, repeat-shot detection, out-of-range rejection and win/lose detection. Sits between the coordinate/button input logic and the LED-matrix scanner.

---
 rtl/ataque_pkg.sv | 12 +
 rtl/debounce_botao.sv | 18 +
 rtl/gerenciador_de_ataque_param.sv | 131 +++++++++++++
 tb/tb_gerenciador_de_ataque_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ataque_pkg.sv
// ataque_pkg: FSM states, LED status colours and cell-index helper shared by the attack manager.
package ataque_pkg;
    typedef enum logic [1:0] {OCIOSO, AGUARDA, AVALIA, FIM} estado_t;
    // LED colours packed as {R, G, B}
    localparam logic [2:0] COR_ACERTO   = 3'b010;
    localparam logic [2:0] COR_ERRO     = 3'b100;
    localparam logic [2:0] COR_REPETIDO = 3'b001;
    localparam logic [2:0] COR_INVALIDO = 3'b101;
    function automatic int idx_celula(input int c, input int l, input int rows);
        return c * rows + l;
    endfunction
endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: output goes high only after the input has been high for CICLOS consecutive cycles.
module debounce_botao #(
    parameter int CICLOS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic botao_i,
    output logic botao_o
);
    localparam int CW = $clog2(CICLOS + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = !botao_i ? '0 : cnt_q == CW'(CICLOS) ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign botao_o = cnt_q == CW'(CICLOS);
endmodule

// File: rtl/gerenciador_de_ataque_param.sv
// gerenciador_de_ataque_param: naval-battle shot evaluator with shot budget, hit count and win/lose detection.
// Optional macro ATAQUE_DEBOUNCE_EN routes confirmar through debounce_botao before edge detection.
module gerenciador_de_ataque_param
    import ataque_pkg::*;
#(
    parameter int COLS            = 5,
    parameter int ROWS            = 7,
    parameter int COORD_W         = 3,
    parameter int MAX_TIROS       = 12,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               confirmar,
    input  logic [COORD_W-1:0]                 coordColuna,
    input  logic [COORD_W-1:0]                 coordLinha,
    input  logic [COLS*ROWS-1:0]               mapa,
    output logic [COLS*ROWS-1:0]               matriz,
    output logic                               LED_R,
    output logic                               LED_G,
    output logic                               LED_B,
    output logic [$clog2(COLS*ROWS+1)-1:0]     acertos,
    output logic [$clog2(MAX_TIROS+1)-1:0]     tiros_restantes,
    output logic                               fim_de_jogo,
    output logic                               vitoria
);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N + 1);
    localparam int TW = $clog2(MAX_TIROS + 1);

    if (MAX_TIROS < 1 || DEBOUNCE_CICLOS < 1 || (1 << COORD_W) < COLS || (1 << COORD_W) < ROWS) begin : g_parametros_invalidos
        $error("gerenciador_de_ataque_param: invalid parameters");
    end

    logic limpa, botao, borda, avalia, invalido, repetido, acerto, novo, venceu, perdeu;
    assign limpa = reset | ~enable;

`ifdef ATAQUE_DEBOUNCE_EN
    debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_debounce (
        .clk     (clk),
        .reset   (limpa),
        .botao_i (confirmar),
        .botao_o (botao)
    );
`else
    // input register keeps the asynchronous button off the FSM decode path
    logic sinc_q;
    always_ff @(posedge clk) sinc_q <= limpa ? 1'b0 : confirmar;
    assign botao = sinc_q;
`endif

    estado_t estado_q, estado_d;
    logic confirmar_q, confirmar_d, fim_q, fim_d, vitoria_q, vitoria_d;
    logic [COORD_W-1:0] col_q, col_d, lin_q, lin_d;
    logic [N-1:0] matriz_q, matriz_d, feitos_q, feitos_d, sel, matriz_n;
    logic [2:0] cor_q, cor_d;
    logic [AW-1:0] acertos_q, acertos_d;
    logic [TW-1:0] tiros_q, tiros_d, tiros_n;

    always_ff @(posedge clk) begin
        if (limpa) begin
            estado_q    <= OCIOSO;
            confirmar_q <= 1'b0;
            col_q       <= '0;
            lin_q       <= '0;
            matriz_q    <= '0;
            feitos_q    <= '0;
            cor_q       <= '0;
            acertos_q   <= '0;
            tiros_q     <= TW'(MAX_TIROS);
            fim_q       <= 1'b0;
            vitoria_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            confirmar_q <= confirmar_d;
            col_q       <= col_d;
            lin_q       <= lin_d;
            matriz_q    <= matriz_d;
            feitos_q    <= feitos_d;
            cor_q       <= cor_d;
            acertos_q   <= acertos_d;
            tiros_q     <= tiros_d;
            fim_q       <= fim_d;
            vitoria_q   <= vitoria_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO:  estado_d = AGUARDA;
            AGUARDA: estado_d = borda ? AVALIA : AGUARDA;
            AVALIA:  estado_d = venceu || perdeu ? FIM : AGUARDA;
            FIM:     estado_d = FIM;
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        borda       = botao & ~confirmar_q;
        avalia      = estado_q == AVALIA;
        invalido    = int'(col_q) >= COLS || int'(lin_q) >= ROWS;
        sel         = invalido ? '0 : N'(1) << idx_celula(int'(col_q), int'(lin_q), ROWS);
        repetido    = |(sel & (matriz_q | feitos_q));
        acerto      = |(sel & mapa) & ~repetido;
        novo        = ~invalido & ~repetido;
        matriz_n    = acerto ? matriz_q | sel : matriz_q;
        tiros_n     = novo && tiros_q != '0 ? tiros_q - 1'b1 : tiros_q;
        venceu      = matriz_n == mapa && |mapa;
        perdeu      = tiros_n == '0;
        confirmar_d = botao;
        col_d       = estado_q == AGUARDA && borda ? coordColuna : col_q;
        lin_d       = estado_q == AGUARDA && borda ? coordLinha : lin_q;
        matriz_d    = avalia ? matriz_n : matriz_q;
        feitos_d    = avalia && novo && !acerto ? feitos_q | sel : feitos_q;
        acertos_d   = avalia && acerto && acertos_q != AW'(N) ? acertos_q + 1'b1 : acertos_q;
        tiros_d     = avalia ? tiros_n : tiros_q;
        cor_d       = !avalia ? cor_q : invalido ? COR_INVALIDO : repetido ? COR_REPETIDO :
                      acerto ? COR_ACERTO : COR_ERRO;
        fim_d       = fim_q | (avalia & (venceu | perdeu));
        vitoria_d   = vitoria_q | (avalia & venceu);
    end

    assign matriz          = matriz_q;
    assign {LED_R, LED_G, LED_B} = cor_q;
    assign acertos         = acertos_q;
    assign tiros_restantes = tiros_q;
    assign fim_de_jogo     = fim_q;
    assign vitoria         = vitoria_q;
endmodule

// File: tb/tb_gerenciador_de_ataque_param.sv
// tb_gerenciador_de_ataque_param: directed, table-driven bench for the attack manager (default build).
module tb_gerenciador_de_ataque_param;
    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b1, confirmar = 1'b0;
    logic [2:0] col = '0, lin = '0;
    logic [34:0] mapa = 35'h7_0000_1071;
    logic [34:0] matriz;
    logic led_r, led_g, led_b, fim, vit;
    logic [5:0] acertos;
    logic [3:0] tiros;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic [2:0]  c, l;
        logic [34:0] m;
        logic [2:0]  rgb;
        logic [5:0]  ac;
        logic [3:0]  tr;
        logic        fim, vit;
    } vec_t;
    vec_t v[14];

    gerenciador_de_ataque_param #(.COLS(5), .ROWS(7), .COORD_W(3), .MAX_TIROS(12), .DEBOUNCE_CICLOS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .confirmar       (confirmar),
        .coordColuna     (col),
        .coordLinha      (lin),
        .mapa            (mapa),
        .matriz          (matriz),
        .LED_R           (led_r),
        .LED_G           (led_g),
        .LED_B           (led_b),
        .acertos         (acertos),
        .tiros_restantes (tiros),
        .fim_de_jogo     (fim),
        .vitoria         (vit)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nome, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [34:0] m, input logic [2:0] rgb,
                             input logic [5:0] ac, input logic [3:0] tr, input logic f, input logic vt);
        check({tag, ".matriz"}, 64'(matriz), 64'(m));
        check({tag, ".rgb"}, 64'({led_r, led_g, led_b}), 64'(rgb));
        check({tag, ".acertos"}, 64'(acertos), 64'(ac));
        check({tag, ".tiros"}, 64'(tiros), 64'(tr));
        check({tag, ".fim"}, 64'(fim), 64'(f));
        check({tag, ".vitoria"}, 64'(vit), 64'(vt));
    endtask

    task automatic tiro(input logic [2:0] c, input logic [2:0] l, input int hold);
        @(negedge clk);
        col = c;
        lin = l;
        confirmar = 1'b1;
        repeat (hold) @(negedge clk);
        confirmar = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        confirmar = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        v[0]  = '{3'd0, 3'd0, 35'h1,           3'b010, 6'd1, 4'd11, 1'b0, 1'b0};
        v[1]  = '{3'd2, 3'd3, 35'h1,           3'b100, 6'd1, 4'd10, 1'b0, 1'b0};
        v[2]  = '{3'd2, 3'd3, 35'h1,           3'b001, 6'd1, 4'd10, 1'b0, 1'b0};
        v[3]  = '{3'd6, 3'd2, 35'h1,           3'b101, 6'd1, 4'd10, 1'b0, 1'b0};
        v[4]  = '{3'd0, 3'd0, 35'h1,           3'b001, 6'd1, 4'd10, 1'b0, 1'b0};
        v[5]  = '{3'd2, 3'd7, 35'h1,           3'b101, 6'd1, 4'd10, 1'b0, 1'b0};
        v[6]  = '{3'd0, 3'd4, 35'h11,          3'b010, 6'd2, 4'd9,  1'b0, 1'b0};
        v[7]  = '{3'd0, 3'd5, 35'h31,          3'b010, 6'd3, 4'd8,  1'b0, 1'b0};
        v[8]  = '{3'd0, 3'd6, 35'h71,          3'b010, 6'd4, 4'd7,  1'b0, 1'b0};
        v[9]  = '{3'd1, 3'd5, 35'h1071,        3'b010, 6'd5, 4'd6,  1'b0, 1'b0};
        v[10] = '{3'd4, 3'd4, 35'h1_0000_1071, 3'b010, 6'd6, 4'd5,  1'b0, 1'b0};
        v[11] = '{3'd4, 3'd5, 35'h3_0000_1071, 3'b010, 6'd7, 4'd4,  1'b0, 1'b0};
        v[12] = '{3'd4, 3'd6, 35'h7_0000_1071, 3'b010, 6'd8, 4'd3,  1'b1, 1'b1};
        v[13] = '{3'd3, 3'd3, 35'h7_0000_1071, 3'b010, 6'd8, 4'd3,  1'b1, 1'b1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_all("reset", '0, 3'b000, 6'd0, 4'd12, 1'b0, 1'b0);

        // two-edge latency: nothing at N+1, result at N+2
        @(negedge clk);
        col = 3'd0;
        lin = 3'd0;
        confirmar = 1'b1;
        @(negedge clk);
        confirmar = 1'b0;
        @(negedge clk);
        check("lat_n1.matriz", 64'(matriz), 64'h0);
        @(negedge clk);
        check("lat_n2.matriz", 64'(matriz), 64'h1);
        check("lat_n2.tiros", 64'(tiros), 64'd11);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            tiro(v[i].c, v[i].l, 1);
            check_all($sformatf("vec%0d", i), v[i].m, v[i].rgb, v[i].ac, v[i].tr, v[i].fim, v[i].vit);
        end

        do_reset();
        tiro(3'd3, 3'd3, 10);
        check_all("held", '0, 3'b100, 6'd0, 4'd11, 1'b0, 1'b0);

        do_reset();
        for (int k = 0; k < 12; k++) begin
            tiro(k < 7 ? 3'd2 : 3'd3, k < 7 ? 3'(k) : 3'(k - 7), 1);
            check($sformatf("loss%0d.tiros", k), 64'(tiros), 64'(11 - k));
            check($sformatf("loss%0d.fim", k), 64'(fim), 64'(k == 11));
        end
        check_all("loss_end", '0, 3'b100, 6'd0, 4'd0, 1'b1, 1'b0);
        tiro(3'd0, 3'd0, 1);
        check_all("loss_ignored", '0, 3'b100, 6'd0, 4'd0, 1'b1, 1'b0);

        // enable dropped while the shot is in AVALIA
        do_reset();
        tiro(3'd0, 3'd0, 1);
        check_all("pre_clear", 35'h1, 3'b010, 6'd1, 4'd11, 1'b0, 1'b0);
        @(negedge clk);
        col = 3'd0;
        lin = 3'd4;
        confirmar = 1'b1;
        @(negedge clk);
        confirmar = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_all("clear_avalia", '0, 3'b000, 6'd0, 4'd12, 1'b0, 1'b0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        tiro(3'd0, 3'd4, 1);
        check_all("after_clear", 35'h10, 3'b010, 6'd1, 4'd11, 1'b0, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        col = 3'd0;
        lin = 3'd0;
        confirmar = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        confirmar = 1'b0;
        repeat (4) @(negedge clk);
        check_all("reset_with_edge", '0, 3'b000, 6'd0, 4'd12, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
